// File: rtl/xy_trace_capture.sv
// Cycle-stamped X/Y trace observer.
// Records {stamp, X, Y} into a first-word-fall-through FIFO when the pair changes.
module xy_trace_capture #(
  parameter int DEPTH       = 16,
  parameter bit CAPTURE_ALL = 1'b0
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     En,
  input  logic                     Clear,
  input  logic [31:0]              X,
  input  logic [31:0]              Y,
  input  logic                     Rd_Ready,
  output logic                     Rd_Valid,
  output logic [31:0]              Rd_Stamp,
  output logic [31:0]              Rd_X,
  output logic [31:0]              Rd_Y,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [31:0]  r_stamp;
  logic [31:0]  r_prev_x;
  logic [31:0]  r_prev_y;
  logic         r_prev_valid;
  logic         r_overflow;
  logic [95:0]  r_mem [DEPTH];

  logic         w_empty;
  logic         w_full;
  logic         w_push_req;
  logic         w_pop;
  logic         w_push;
  logic         w_drop;
  logic [95:0]  w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_push_req = En && (!r_prev_valid || (X != r_prev_x) ||
                             (Y != r_prev_y) || CAPTURE_ALL);
  assign w_pop      = !Clear && !w_empty && Rd_Ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push     = !Clear && w_push_req && (!w_full || w_pop);
  assign w_drop     = !Clear && w_push_req && w_full && !w_pop;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_stamp      <= '0;
      r_prev_x     <= '0;
      r_prev_y     <= '0;
      r_prev_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (Clear) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_stamp      <= '0;
      r_prev_x     <= '0;
      r_prev_y     <= '0;
      r_prev_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop) r_overflow <= 1'b1;
      // History tracks dropped samples too, so a drop never causes a later duplicate.
      if (En) begin
        r_stamp      <= r_stamp + 32'd1;
        r_prev_x     <= X;
        r_prev_y     <= Y;
        r_prev_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {r_stamp, X, Y};
  end

  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
  assign Rd_Valid = !w_empty;
  assign Rd_Stamp = w_empty ? 32'd0 : w_head[95:64];
  assign Rd_X     = w_empty ? 32'd0 : w_head[63:32];
  assign Rd_Y     = w_empty ? 32'd0 : w_head[31:0];
  assign Count    = r_wr_ptr - r_rd_ptr;
  assign Overflow = r_overflow;

endmodule

// File: tb/tb_xy_trace_capture.sv
// Directed bench for xy_trace_capture: vector table plus hand-written corner sequences.
module tb_xy_trace_capture;

  logic        Clk, Reset;
  logic        en, clr, rr;
  logic [31:0] x, y;
  logic        rv, ovf;
  logic [31:0] rst_s, rx, ry;
  logic [4:0]  cnt;

  logic        en2, clr2, rr2;
  logic [31:0] x2, y2;
  logic        rv2, ovf2;
  logic [31:0] rst_s2, rx2, ry2;
  logic [2:0]  cnt2;

  int n_vec = 0;
  int n_err = 0;

  xy_trace_capture #(.DEPTH(16), .CAPTURE_ALL(1'b0)) dut (
    .Clk(Clk), .Reset(Reset), .En(en), .Clear(clr), .X(x), .Y(y),
    .Rd_Ready(rr), .Rd_Valid(rv), .Rd_Stamp(rst_s), .Rd_X(rx), .Rd_Y(ry),
    .Count(cnt), .Overflow(ovf)
  );

  xy_trace_capture #(.DEPTH(4), .CAPTURE_ALL(1'b1)) dut_all (
    .Clk(Clk), .Reset(Reset), .En(en2), .Clear(clr2), .X(x2), .Y(y2),
    .Rd_Ready(rr2), .Rd_Valid(rv2), .Rd_Stamp(rst_s2), .Rd_X(rx2), .Rd_Y(ry2),
    .Count(cnt2), .Overflow(ovf2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        en;
    logic        clr;
    logic        rr;
    logic [31:0] x;
    logic [31:0] y;
    logic        e_valid;
    logic [31:0] e_stamp;
    logic [31:0] e_x;
    logic [31:0] e_y;
    logic [31:0] e_cnt;
    logic        e_ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_head(input string name, input int idx, input logic v, input logic [31:0] s,
                          input logic [31:0] ex, input logic [31:0] c);
    chk({name, "_valid"}, idx, {31'd0, rv}, {31'd0, v});
    chk({name, "_stamp"}, idx, rst_s, s);
    chk({name, "_x"}, idx, rx, ex);
    chk({name, "_count"}, idx, {27'd0, cnt}, c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             en  clr rr  x   y   valid stamp ex  ey  cnt ovf
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'd1, 32'd2, 1'b1, 32'd0, 32'd1, 32'd2, 32'd1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'd1, 32'd2, 1'b1, 32'd0, 32'd1, 32'd2, 32'd1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'd1, 32'd2, 1'b1, 32'd0, 32'd1, 32'd2, 32'd1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'd1, 32'd2, 1'b1, 32'd0, 32'd1, 32'd2, 32'd1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'd1, 32'd2, 1'b1, 32'd0, 32'd1, 32'd2, 32'd1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'd1, 32'd2, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'd1, 32'd0, 1'b1, 32'd0, 32'd1, 32'd0, 32'd1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 32'd2, 32'd0, 1'b1, 32'd1, 32'd2, 32'd0, 32'd1, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 32'd3, 32'd0, 1'b1, 32'd2, 32'd3, 32'd0, 32'd1, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 32'd3, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0};

    Reset = 1'b0;
    en = 1'b1; clr = 1'b0; rr = 1'b0; x = 32'd1; y = 32'd2;
    en2 = 1'b0; clr2 = 1'b0; rr2 = 1'b0; x2 = 32'd0; y2 = 32'd0;
    #50;
    chk("reset_valid", 0, {31'd0, rv}, 32'd0);
    chk("reset_count", 0, {27'd0, cnt}, 32'd0);
    chk("reset_ovf", 0, {31'd0, ovf}, 32'd0);
    chk("reset_x", 0, rx, 32'd0);
    #2 Reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      en = vecs[i].en; clr = vecs[i].clr; rr = vecs[i].rr;
      x = vecs[i].x; y = vecs[i].y;
      step();
      chk("vec_valid", i, {31'd0, rv}, {31'd0, vecs[i].e_valid});
      chk("vec_stamp", i, rst_s, vecs[i].e_stamp);
      chk("vec_x", i, rx, vecs[i].e_x);
      chk("vec_y", i, ry, vecs[i].e_y);
      chk("vec_count", i, {27'd0, cnt}, vecs[i].e_cnt);
      chk("vec_ovf", i, {31'd0, ovf}, {31'd0, vecs[i].e_ovf});
    end

    // overflow: 20 changes into a 16-deep FIFO, then drain
    en = 1'b1; clr = 1'b1; rr = 1'b0; step(); clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      x = 32'd100 + i; step();
    end
    chk("ovf_count", 0, {27'd0, cnt}, 32'd16);
    chk("ovf_flag", 0, {31'd0, ovf}, 32'd1);
    en = 1'b0; rr = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk_head("ovf_drain", k, 1'b1, k, 32'd100 + k, 16 - k);
      step();
    end
    chk("ovf_empty", 0, {31'd0, rv}, 32'd0);
    chk("ovf_sticky", 0, {31'd0, ovf}, 32'd1);

    // full with simultaneous pop and push
    en = 1'b1; clr = 1'b1; rr = 1'b0; step(); clr = 1'b0;
    chk("clr_ovf", 0, {31'd0, ovf}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      x = 32'd200 + i; step();
    end
    chk_head("full", 0, 1'b1, 32'd0, 32'd200, 32'd16);
    chk("full_ovf", 0, {31'd0, ovf}, 32'd0);
    x = 32'd300; rr = 1'b1; step();
    chk_head("full_pp", 0, 1'b1, 32'd1, 32'd201, 32'd16);
    chk("full_pp_ovf", 0, {31'd0, ovf}, 32'd0);
    en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk_head("full_drain", k, 1'b1, 32'd1 + k, (k < 15) ? 32'd201 + k : 32'd300, 16 - k);
      step();
    end
    chk("full_empty_cnt", 0, {27'd0, cnt}, 32'd0);

    // asynchronous reset mid-burst
    en = 1'b1; clr = 1'b1; rr = 1'b0; step(); clr = 1'b0;
    for (int i = 0; i < 7; i++) begin
      x = 32'd400 + i; step();
    end
    chk("burst_count", 0, {27'd0, cnt}, 32'd7);
    en = 1'b0;
    #2 Reset = 1'b0;
    #1;
    chk("async_valid", 0, {31'd0, rv}, 32'd0);
    chk("async_count", 0, {27'd0, cnt}, 32'd0);
    chk("async_ovf", 0, {31'd0, ovf}, 32'd0);
    chk("async_stamp", 0, rst_s, 32'd0);
    #1 Reset = 1'b1;
    step();
    chk("release_noen_count", 0, {27'd0, cnt}, 32'd0);

    // capture-all instance with En toggling 1,0,1
    x2 = 32'd5; y2 = 32'd5; rr2 = 1'b0;
    en2 = 1'b1; step();
    en2 = 1'b0; step();
    chk("ca_mid_count", 0, {29'd0, cnt2}, 32'd1);
    en2 = 1'b1; step();
    chk("ca_count", 0, {29'd0, cnt2}, 32'd2);
    chk("ca_stamp0", 0, rst_s2, 32'd0);
    chk("ca_x0", 0, rx2, 32'd5);
    en2 = 1'b0; rr2 = 1'b1; step();
    chk("ca_stamp1", 0, rst_s2, 32'd1);
    chk("ca_count1", 0, {29'd0, cnt2}, 32'd1);
    step();
    chk("ca_empty", 0, {31'd0, rv2}, 32'd0);
    chk("ca_ovf", 0, {31'd0, ovf2}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
